keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// Keypad row scanner with debounce and a valid/ready command port.
// Left/right moves a saturating player lane; fire is passed through.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 3,
    parameter int POS_MIN      = 1,
    parameter int POS_MAX      = 6,
    parameter int POS_INIT     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic [2:0] playPos
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0] PMIN  = 3'(POS_MIN);
    localparam logic [2:0] PMAX  = 3'(POS_MAX);
    localparam logic [2:0] PINIT = 3'(POS_INIT);

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        ISSUE,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q;
    logic [3:0]      row_q, row_d;
    logic [3:0]      cap_q, cap_d;
    logic [1:0]      code_q, code_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      pos_q, pos_d;
    logic            tick;
    logic            key_hit;
    logic [1:0]      key_code;
    logic [3:0]      row_next;

    assign tick      = (div_q == DIV_LAST);
    assign row_next  = {row_q[2:0], row_q[3]};
    assign keypadRow = row_q;
    assign cmd_valid = (state_q == ISSUE);
    assign cmd_code  = code_q;
    assign playPos   = pos_q;

    // Free-running sample divider; wraps on the sample tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DW'(1);
    end

    // Key decode: only a single low column 0 on a mapped row is a key.
    always_comb begin
        key_hit  = 1'b0;
        key_code = 2'b00;
        if (keypadCol == 4'b1110) begin
            case (row_q)
                4'b1110: begin key_hit = 1'b1; key_code = 2'b10; end
                4'b1011: begin key_hit = 1'b1; key_code = 2'b00; end
                4'b0111: begin key_hit = 1'b1; key_code = 2'b01; end
                default: begin key_hit = 1'b0; key_code = 2'b00; end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            row_q   <= 4'b1110;
            cap_q   <= 4'b1110;
            code_q  <= 2'b00;
            cnt_q   <= '0;
            pos_q   <= PINIT;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    // Next-state: scan, debounce press, hold command, debounce release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cap_d   = cap_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        unique case (state_q)
            SCAN: begin
                if (tick) begin
                    row_d = row_next;
                    if (key_hit) begin
                        cap_d   = row_q;
                        code_d  = key_code;
                        cnt_d   = CNT_ONE;
                        state_d = CONFIRM;
                        if (CNT_ONE >= CNT_LAST) begin
                            cnt_d   = '0;
                            row_d   = row_q;
                            state_d = ISSUE;
                        end
                    end
                end
            end
            CONFIRM: begin
                if (tick) begin
                    row_d = row_next;
                    if (row_q == cap_q) begin
                        if (key_hit && key_code == code_q) begin
                            cnt_d = cnt_q + CNT_ONE;
                            if (cnt_d == CNT_LAST) begin
                                cnt_d   = '0;
                                row_d   = row_q;
                                state_d = ISSUE;
                            end
                        end else begin
                            cnt_d   = '0;
                            state_d = SCAN;
                        end
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                    case (code_q)
                        2'b00: if (pos_q != PMIN) pos_d = pos_q - 3'd1;
                        2'b01: if (pos_q != PMAX) pos_d = pos_q + 3'd1;
                        default: pos_d = pos_q;
                    endcase
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (keypadCol == 4'b1111) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_LAST) begin
                            cnt_d   = '0;
                            row_d   = row_next;
                            state_d = SCAN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

endmodule
